// File: rtl/bulls_cows_game_ctrl.sv
// Two-player Bulls & Cows sequencer: secret entry, alternating guesses, scoring,
// invalid-entry error hold and winner detection. Emits abstract status only.
module bulls_cows_game_ctrl #(
  parameter int ERR_CYCLES = 100_000_000,
  parameter int MAX_DIGIT  = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        confirma,
  input  logic [15:0] SW,
  output logic [2:0]  state_o,
  output logic        player_o,
  output logic [2:0]  bulls_o,
  output logic [2:0]  cows_o,
  output logic        err_o,
  output logic        win_o,
  output logic        winner_o,
  output logic [15:0] LED
);

  localparam int CW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
  localparam logic [3:0]    MAX_NIB  = 4'(MAX_DIGIT);
  localparam logic [CW-1:0] ERR_LOAD = CW'(ERR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_SET_J1   = 3'd0,
    S_SET_J2   = 3'd1,
    S_GUESS_J1 = 3'd2,
    S_GUESS_J2 = 3'd3,
    S_ERROR    = 3'd4,
    S_WIN      = 3'd5
  } state_t;

  state_t        state_q, state_n, ret_q, ret_n;
  logic [15:0]   sec1_q, sec1_n, sec2_q, sec2_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    bulls_q, bulls_n, cows_q, cows_n;
  logic          winner_q, winner_n;
  logic          confirma_q, press_q;
  logic [15:0]   led_q;
  logic          sw_valid;
  logic [15:0]   cmp_sec;
  logic [2:0]    g_bulls, g_cows;

  function automatic logic entry_valid(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > MAX_NIB) ok = 1'b0;
      for (int j = i + 1; j < 4; j++)
        if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [15:0] therm(input logic [2:0] b, input logic [2:0] c);
    logic [15:0] l;
    l = '0;
    for (int i = 0; i < 4; i++) begin
      l[15-i] = (3'(i) < b);
      l[i]    = (3'(i) < c);
    end
    return l;
  endfunction

  assign sw_valid = entry_valid(SW);
  // Each player guesses the opponent's secret.
  assign cmp_sec  = (state_q == S_GUESS_J1) ? sec2_q : sec1_q;

  always_comb begin
    g_bulls = '0;
    g_cows  = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (SW[4*i +: 4] == cmp_sec[4*j +: 4]) begin
          if (i == j) g_bulls = g_bulls + 3'd1;
          else        g_cows  = g_cows + 3'd1;
        end
  end

  always_comb begin
    state_n  = state_q;
    ret_n    = ret_q;
    sec1_n   = sec1_q;
    sec2_n   = sec2_q;
    cnt_n    = cnt_q;
    bulls_n  = bulls_q;
    cows_n   = cows_q;
    winner_n = winner_q;
    case (state_q)
      S_SET_J1, S_SET_J2: begin
        if (press_q) begin
          if (sw_valid) begin
            if (state_q == S_SET_J1) begin
              sec1_n  = SW;
              state_n = S_SET_J2;
            end else begin
              sec2_n  = SW;
              state_n = S_GUESS_J1;
            end
          end else begin
            ret_n   = state_q;
            cnt_n   = ERR_LOAD;
            state_n = S_ERROR;
          end
        end
      end
      S_GUESS_J1, S_GUESS_J2: begin
        if (press_q) begin
          if (sw_valid) begin
            bulls_n = g_bulls;
            cows_n  = g_cows;
            if (g_bulls == 3'd4) begin
              winner_n = (state_q == S_GUESS_J2);
              state_n  = S_WIN;
            end else begin
              state_n = (state_q == S_GUESS_J1) ? S_GUESS_J2 : S_GUESS_J1;
            end
          end else begin
            ret_n   = state_q;
            cnt_n   = ERR_LOAD;
            state_n = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        if (cnt_q == '0) state_n = ret_q;
        else             cnt_n   = cnt_q - 1'b1;
      end
      S_WIN:   state_n = S_WIN;
      default: state_n = S_SET_J1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_SET_J1;
      ret_q      <= S_SET_J1;
      sec1_q     <= '0;
      sec2_q     <= '0;
      cnt_q      <= '0;
      bulls_q    <= '0;
      cows_q     <= '0;
      winner_q   <= 1'b0;
      confirma_q <= confirma;  // a button held through reset is not a press
      press_q    <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_n;
      ret_q      <= ret_n;
      sec1_q     <= sec1_n;
      sec2_q     <= sec2_n;
      cnt_q      <= cnt_n;
      bulls_q    <= bulls_n;
      cows_q     <= cows_n;
      winner_q   <= winner_n;
      confirma_q <= confirma;
      press_q    <= confirma & ~confirma_q;
      led_q      <= therm(bulls_n, cows_n);
    end
  end

  // Player shown in ERROR is the one whose entry was rejected.
  always_comb begin
    player_o = 1'b0;
    case (state_q)
      S_SET_J2, S_GUESS_J2: player_o = 1'b1;
      S_ERROR:              player_o = (ret_q == S_SET_J2) || (ret_q == S_GUESS_J2);
      S_WIN:                player_o = winner_q;
      default:              player_o = 1'b0;
    endcase
  end

  assign state_o  = state_q;
  assign bulls_o  = bulls_q;
  assign cows_o   = cows_q;
  assign err_o    = (state_q == S_ERROR);
  assign win_o    = (state_q == S_WIN);
  assign winner_o = winner_q;
  assign LED      = led_q;

endmodule

// File: tb/tb_bulls_cows_game_ctrl.sv
// Directed bench for bulls_cows_game_ctrl: entry validation, scoring, error hold,
// win detection, press edge detection and reset priority.
module tb_bulls_cows_game_ctrl;

  localparam int ERR_CYCLES = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        confirma;
  logic [15:0] SW;
  logic [2:0]  state_o;
  logic        player_o;
  logic [2:0]  bulls_o;
  logic [2:0]  cows_o;
  logic        err_o;
  logic        win_o;
  logic        winner_o;
  logic [15:0] LED;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  bulls_cows_game_ctrl #(.ERR_CYCLES(ERR_CYCLES), .MAX_DIGIT(9)) dut (
    .clock(clock), .reset(reset), .confirma(confirma), .SW(SW),
    .state_o(state_o), .player_o(player_o), .bulls_o(bulls_o), .cows_o(cows_o),
    .err_o(err_o), .win_o(win_o), .winner_o(winner_o), .LED(LED)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference thermometer: bulls fill from LED[15] down, cows from LED[0] up.
  function automatic logic [15:0] led_model(input logic [2:0] b, input logic [2:0] c);
    logic [3:0] bt;
    logic [3:0] ct;
    bt = 4'hF << (3'd4 - b);
    ct = 4'hF >> (3'd4 - c);
    return {bt, 8'h00, ct};
  endfunction

  task automatic press(input logic [15:0] sw);
    @(negedge clock);
    SW = sw;
    confirma = 1'b1;
    @(negedge clock);
    confirma = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},  state_o,  3'd0);
    check({tag, "_player"}, player_o, 1'b0);
    check({tag, "_bulls"},  bulls_o,  3'd0);
    check({tag, "_cows"},   cows_o,   3'd0);
    check({tag, "_err"},    err_o,    1'b0);
    check({tag, "_win"},    win_o,    1'b0);
    check({tag, "_winner"}, winner_o, 1'b0);
    check({tag, "_led"},    LED,      16'h0000);
  endtask

  // Expected score entries are {bulls, cows} pushed at stimulus time.
  task automatic check_score(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_bulls"}, bulls_o, e[5:3]);
    check({tag, "_cows"},  cows_o,  e[2:0]);
    check({tag, "_led"},   LED,     led_model(e[5:3], e[2:0]));
  endtask

  task automatic err_window(input string tag, input logic [2:0] ret_state);
    int cnt;
    cnt = 0;
    while (err_o && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    check({tag, "_err_len"},   cnt,     ERR_CYCLES);
    check({tag, "_ret_state"}, state_o, ret_state);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    confirma = 1'b0;
    SW = 16'h0000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("rst");

    // Invalid secrets: repeated digit, then a non-decimal nibble.
    press(16'h1123);
    check("t3a_state", state_o, 3'd4);
    check("t3a_err", err_o, 1'b1);
    check("t3a_player", player_o, 1'b0);
    err_window("t3a", 3'd0);
    press(16'h12A4);
    check("t3b_state", state_o, 3'd4);
    err_window("t3b", 3'd0);
    check("t3b_bulls", bulls_o, 3'd0);

    // Secret entry.
    press(16'h1234);
    check("t1_state1", state_o, 3'd1);
    check("t1_player1", player_o, 1'b1);
    press(16'h5678);
    check("t1_state2", state_o, 3'd2);
    check("t1_player2", player_o, 1'b0);
    check("t1_bulls_kept", bulls_o, 3'd0);

    // J1 guess 8765 vs 5678: all digits misplaced.
    exp_q.push_back({10'd0, 3'd0, 3'd4});
    press(16'h8765);
    check("t2_state", state_o, 3'd3);
    check("t2_player", player_o, 1'b1);
    check_score("t2");

    // Held button: J2 guess 2134 vs 1234 must be scored exactly once.
    exp_q.push_back({10'd0, 3'd2, 3'd2});
    @(negedge clock);
    SW = 16'h2134;
    confirma = 1'b1;
    repeat (50) @(negedge clock);
    confirma = 1'b0;
    @(negedge clock);
    check("t5_state", state_o, 3'd2);
    check_score("t5");

    // J1 guess 5679 vs 5678.
    exp_q.push_back({10'd0, 3'd3, 3'd0});
    press(16'h5679);
    check("g3_state", state_o, 3'd3);
    check_score("g3");

    // Invalid guess: score held, player held, return to GUESS_J2.
    press(16'h9999);
    check("ge_state", state_o, 3'd4);
    check("ge_player", player_o, 1'b1);
    check("ge_bulls", bulls_o, 3'd3);
    err_window("ge", 3'd3);
    check("ge_bulls_after", bulls_o, 3'd3);
    check("ge_led_after", LED, 16'hE000);

    // A winning press during ERROR is ignored.
    press(16'hABCD);
    press(16'h1234);
    check("gi_state", state_o, 3'd4);
    while (err_o && n_tests < 100000) @(negedge clock);
    check("gi_state_after", state_o, 3'd3);
    check("gi_win", win_o, 1'b0);

    // J2 wins with 1234 vs sec1=1234.
    exp_q.push_back({10'd0, 3'd4, 3'd0});
    press(16'h1234);
    check("t4_state", state_o, 3'd5);
    check("t4_win", win_o, 1'b1);
    check("t4_winner", winner_o, 1'b1);
    check("t4_player", player_o, 1'b1);
    check_score("t4");
    press(16'h5678);
    press(16'hAAAA);
    check("t4_terminal_state", state_o, 3'd5);
    check("t4_terminal_bulls", bulls_o, 3'd4);
    check("t4_terminal_led", LED, 16'hF000);

    do_reset();
    check_reset_vals("win_rst");

    // Reset on the same edge as a registered press in GUESS_J1, button still held.
    press(16'h1234);
    press(16'h5678);
    check("t6a_pre_state", state_o, 3'd2);
    @(negedge clock);
    SW = 16'h8765;
    confirma = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    confirma = 1'b0;
    @(negedge clock);
    check_reset_vals("t6a");

    // Reset mid-ERROR discards the timer.
    press(16'h1234);
    press(16'h12A4);
    check("t6b_pre_state", state_o, 3'd4);
    repeat (3) @(negedge clock);
    do_reset();
    check_reset_vals("t6b");
    repeat (ERR_CYCLES + 4) @(negedge clock);
    check("t6b_still_set_j1", state_o, 3'd0);
    check("t6b_still_no_err", err_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
